// File: rtl/segre_pkg.sv
// Shared types and default geometry for the MMU-side icache refill path.
// Optional macro SEGRE_ICACHE_LRU_EN (used by segre_icache_victim) selects true LRU replacement.
package segre_pkg;

    localparam int ADDR_SIZE         = 32;
    localparam int ICACHE_LANE_SIZE  = 128;
    localparam int ICACHE_INDEX_SIZE = 2;
    localparam int ICACHE_BYTE_SIZE  = 4;
    localparam int MEM_BEAT_SIZE     = 32;

    typedef enum logic [1:0] {
        REFILL_IDLE,
        REFILL_REQ,
        REFILL_FILL,
        REFILL_RESP
    } refill_fsm_state_e;

endpackage

// File: rtl/segre_icache_victim.sv
// Victim selection for the icache refill: round-robin pointer by default,
// true LRU age counters when SEGRE_ICACHE_LRU_EN is defined.
module segre_icache_victim #(
    parameter int ICACHE_INDEX_SIZE = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         hit_i,
    input  logic [ICACHE_INDEX_SIZE-1:0] hit_index_i,
    input  logic                         touch_i,
    output logic [ICACHE_INDEX_SIZE-1:0] victim_o
);

    localparam int NLINES = 2 ** ICACHE_INDEX_SIZE;

`ifdef SEGRE_ICACHE_LRU_EN

    logic [ICACHE_INDEX_SIZE-1:0] age_q [NLINES];
    logic [ICACHE_INDEX_SIZE-1:0] age_d [NLINES];
    logic [ICACHE_INDEX_SIZE-1:0] max_age;
    logic [ICACHE_INDEX_SIZE-1:0] touch_idx;
    logic                         do_touch;

    always_comb begin
        max_age  = age_q[0];
        victim_o = '0;
        for (int i = 1; i < NLINES; i++) begin
            if (age_q[i] > max_age) begin
                max_age  = age_q[i];
                victim_o = ICACHE_INDEX_SIZE'(i);
            end
        end
    end

    // A refill touch takes priority over a hit in the same cycle.
    always_comb begin
        do_touch  = touch_i | hit_i;
        touch_idx = touch_i ? victim_o : hit_index_i;
        for (int i = 0; i < NLINES; i++) begin
            age_d[i] = age_q[i];
            if (do_touch) begin
                if (ICACHE_INDEX_SIZE'(i) == touch_idx) begin
                    age_d[i] = '0;
                end else if (age_q[i] < age_q[touch_idx]) begin
                    age_d[i] = age_q[i] + ICACHE_INDEX_SIZE'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NLINES; i++) begin
                age_q[i] <= ICACHE_INDEX_SIZE'(i);
            end
        end else begin
            for (int i = 0; i < NLINES; i++) begin
                age_q[i] <= age_d[i];
            end
        end
    end

`else

    logic [ICACHE_INDEX_SIZE-1:0] ptr_q;
    logic [ICACHE_INDEX_SIZE-1:0] ptr_d;
    logic                         unused_hit;

    // Hits carry no information for round-robin replacement.
    assign unused_hit = hit_i ^ (^hit_index_i);

    always_comb begin
        ptr_d = ptr_q;
        if (touch_i) begin
            ptr_d = ptr_q + ICACHE_INDEX_SIZE'(1);
        end
    end

    assign victim_o = ptr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

`endif

endmodule

// File: rtl/segre_mmu_icache_refill.sv
// MMU-side icache miss responder: fetches a line in beats and returns it with a victim index.
// Optional macro SEGRE_ICACHE_LRU_EN switches the victim policy from round-robin to true LRU.
module segre_mmu_icache_refill #(
    parameter int ADDR_SIZE         = 32,
    parameter int ICACHE_LANE_SIZE  = 128,
    parameter int ICACHE_INDEX_SIZE = 2,
    parameter int ICACHE_BYTE_SIZE  = 4,
    parameter int MEM_BEAT_SIZE     = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         ic_access_i,
    input  logic                         ic_miss_i,
    input  logic [ADDR_SIZE-1:0]         ic_addr_i,
    input  logic [ICACHE_INDEX_SIZE-1:0] ic_hit_index_i,
    output logic                         mmu_data_o,
    output logic [ICACHE_LANE_SIZE-1:0]  mmu_wr_data_o,
    output logic [ICACHE_INDEX_SIZE-1:0] mmu_lru_index_o,
    output logic                         mm_rd_req_o,
    output logic [ADDR_SIZE-1:0]         mm_addr_o,
    input  logic                         mm_req_ready_i,
    input  logic                         mm_data_valid_i,
    input  logic [MEM_BEAT_SIZE-1:0]     mm_data_i
);

    import segre_pkg::*;

    localparam int BEATS      = ICACHE_LANE_SIZE / MEM_BEAT_SIZE;
    localparam int BEAT_CNT_W = $clog2(BEATS);

    refill_fsm_state_e            state_q, state_d;
    logic [ADDR_SIZE-1:0]         addr_q, addr_d;
    logic [BEAT_CNT_W-1:0]        beat_cnt_q, beat_cnt_d;
    logic [ICACHE_LANE_SIZE-1:0]  line_q, line_d;
    logic [ICACHE_LANE_SIZE-1:0]  wr_data_q, wr_data_d;
    logic [ICACHE_INDEX_SIZE-1:0] lru_index_q, lru_index_d;
    logic [ICACHE_INDEX_SIZE-1:0] victim;
    logic                         resp;
    logic                         unused_addr_bits;

    // The byte offset is dropped when the line address is latched.
    assign unused_addr_bits = ^ic_addr_i[ICACHE_BYTE_SIZE-1:0];

    segre_icache_victim #(
        .ICACHE_INDEX_SIZE (ICACHE_INDEX_SIZE)
    ) u_victim (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .hit_i       (ic_access_i & ~ic_miss_i),
        .hit_index_i (ic_hit_index_i),
        .touch_i     (resp),
        .victim_o    (victim)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        beat_cnt_d  = beat_cnt_q;
        line_d      = line_q;
        wr_data_d   = wr_data_q;
        lru_index_d = lru_index_q;
        resp        = 1'b0;

        case (state_q)
            REFILL_IDLE: begin
                if (ic_access_i && ic_miss_i) begin
                    addr_d     = {ic_addr_i[ADDR_SIZE-1:ICACHE_BYTE_SIZE], {ICACHE_BYTE_SIZE{1'b0}}};
                    beat_cnt_d = '0;
                    state_d    = REFILL_REQ;
                end
            end
            REFILL_REQ: begin
                if (mm_req_ready_i) begin
                    state_d = REFILL_FILL;
                end
            end
            REFILL_FILL: begin
                if (mm_data_valid_i) begin
                    line_d[int'(beat_cnt_q) * MEM_BEAT_SIZE +: MEM_BEAT_SIZE] = mm_data_i;
                    beat_cnt_d = beat_cnt_q + BEAT_CNT_W'(1);
                    if (beat_cnt_q == BEAT_CNT_W'(BEATS - 1)) begin
                        state_d = REFILL_RESP;
                    end
                end
            end
            REFILL_RESP: begin
                // Capture what is presented so it stays visible after the strobe.
                resp        = 1'b1;
                wr_data_d   = line_q;
                lru_index_d = victim;
                state_d     = REFILL_IDLE;
            end
            default: begin
                state_d = REFILL_IDLE;
            end
        endcase
    end

    assign mmu_data_o      = resp;
    assign mmu_wr_data_o   = resp ? line_q : wr_data_q;
    assign mmu_lru_index_o = resp ? victim : lru_index_q;
    assign mm_rd_req_o     = (state_q == REFILL_REQ);
    assign mm_addr_o       = addr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= REFILL_IDLE;
            addr_q      <= '0;
            beat_cnt_q  <= '0;
            line_q      <= '0;
            wr_data_q   <= '0;
            lru_index_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            beat_cnt_q  <= beat_cnt_d;
            line_q      <= line_d;
            wr_data_q   <= wr_data_d;
            lru_index_q <= lru_index_d;
        end
    end

endmodule

// File: tb/tb_segre_mmu_icache_refill.sv
// Directed, table-driven bench for segre_mmu_icache_refill (honours SEGRE_ICACHE_LRU_EN).
module tb_segre_mmu_icache_refill;

    logic         clk = 1'b0;
    logic         rst;
    logic         ic_access;
    logic         ic_miss;
    logic [31:0]  ic_addr;
    logic [1:0]   ic_hit_index;
    logic         mmu_data_o;
    logic [127:0] mmu_wr_data_o;
    logic [1:0]   mmu_lru_index_o;
    logic         mm_rd_req_o;
    logic [31:0]  mm_addr_o;
    logic         mm_req_ready;
    logic         mm_data_valid;
    logic [31:0]  mm_data;

    int errors = 0;
    int checks = 0;
    int pulses = 0;
    int reqs   = 0;

    always #5 clk = ~clk;

    segre_mmu_icache_refill dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .ic_access_i     (ic_access),
        .ic_miss_i       (ic_miss),
        .ic_addr_i       (ic_addr),
        .ic_hit_index_i  (ic_hit_index),
        .mmu_data_o      (mmu_data_o),
        .mmu_wr_data_o   (mmu_wr_data_o),
        .mmu_lru_index_o (mmu_lru_index_o),
        .mm_rd_req_o     (mm_rd_req_o),
        .mm_addr_o       (mm_addr_o),
        .mm_req_ready_i  (mm_req_ready),
        .mm_data_valid_i (mm_data_valid),
        .mm_data_i       (mm_data)
    );

    // Counts strobes and accepted requests mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (mmu_data_o) pulses++;
        if (mm_rd_req_o && mm_req_ready) reqs++;
    end

    typedef struct {
        logic [31:0]       addr;
        logic [3:0][31:0]  beat;
        int                ready_dly;
        int                gap;
        bit                noise;
        logic [31:0]       exp_addr;
        logic [127:0]      exp_line;
        logic [1:0]        exp_idx;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_refill(input vec_t v, input string tag);
        int p0;
        int r0;
        p0 = pulses;
        r0 = reqs;
        ic_access = 1'b1; ic_miss = 1'b1; ic_addr = v.addr;
        step();
        ic_access = 1'b0; ic_miss = 1'b0;
        chk({tag, " req"}, 128'(mm_rd_req_o), 128'd1);
        chk({tag, " addr"}, 128'(mm_addr_o), 128'(v.exp_addr));
        for (int i = 0; i < v.ready_dly; i++) begin
            step();
            chk({tag, " req held"}, 128'(mm_rd_req_o), 128'd1);
            chk({tag, " addr held"}, 128'(mm_addr_o), 128'(v.exp_addr));
        end
        mm_req_ready = 1'b1;
        step();
        mm_req_ready = 1'b0;
        chk({tag, " req drop"}, 128'(mm_rd_req_o), 128'd0);
        for (int b = 0; b < 4; b++) begin
            for (int g = 0; g < v.gap; g++) begin
                ic_access = v.noise; ic_miss = v.noise; ic_addr = 32'hBAD0_0000;
                step();
            end
            ic_access = v.noise; ic_miss = v.noise; ic_addr = 32'hBAD0_0100;
            mm_data_valid = 1'b1; mm_data = v.beat[b];
            step();
            mm_data_valid = 1'b0;
            if (b < 3) chk({tag, " early strobe"}, 128'(mmu_data_o), 128'd0);
        end
        chk({tag, " strobe"}, 128'(mmu_data_o), 128'd1);
        chk({tag, " line"}, mmu_wr_data_o, v.exp_line);
        chk({tag, " index"}, 128'(mmu_lru_index_o), 128'(v.exp_idx));
        step();
        ic_access = 1'b0; ic_miss = 1'b0;
        chk({tag, " strobe end"}, 128'(mmu_data_o), 128'd0);
        chk({tag, " line hold"}, mmu_wr_data_o, v.exp_line);
        chk({tag, " index hold"}, 128'(mmu_lru_index_o), 128'(v.exp_idx));
        step();
        chk({tag, " no extra req"}, 128'(mm_rd_req_o), 128'd0);
        chk({tag, " pulse count"}, 128'(pulses - p0), 128'd1);
        chk({tag, " req count"}, 128'(reqs - r0), 128'd1);
    endtask

    function automatic vec_t mkvec(input logic [31:0] addr, input logic [127:0] beats,
                                   input int rdly, input int gap, input bit noise,
                                   input logic [31:0] exp_addr, input logic [127:0] exp_line,
                                   input logic [1:0] exp_idx);
        vec_t v;
        v.addr = addr; v.beat = beats; v.ready_dly = rdly; v.gap = gap; v.noise = noise;
        v.exp_addr = exp_addr; v.exp_line = exp_line; v.exp_idx = exp_idx;
        return v;
    endfunction

    function automatic logic [1:0] idx_rr(input logic [1:0] rr, input logic [1:0] lru);
`ifdef SEGRE_ICACHE_LRU_EN
        return lru;
`else
        return rr;
`endif
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no $finish required before 200000");
        $fatal(1);
    end

    initial begin
        vec_t v;
        rst = 1'b1; ic_access = 1'b0; ic_miss = 1'b0; ic_addr = '0; ic_hit_index = '0;
        mm_req_ready = 1'b0; mm_data_valid = 1'b0; mm_data = '0;

        vecs[0] = mkvec(32'h0000_1234, {32'hD, 32'hC, 32'hB, 32'hA}, 0, 0, 0, 32'h0000_1230,
                        128'h0000000D_0000000C_0000000B_0000000A, idx_rr(2'd0, 2'd3));
        vecs[1] = mkvec(32'hDEAD_BEEF, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, 5, 0, 0,
                        32'hDEAD_BEE0, 128'h44444444_33333333_22222222_11111111, idx_rr(2'd1, 2'd2));
        vecs[2] = mkvec(32'h8000_000C, {32'hCAFEF00D, 32'h0BADC0DE, 32'h12345678, 32'h9ABCDEF0}, 0, 2, 0,
                        32'h8000_0000, 128'hCAFEF00D_0BADC0DE_12345678_9ABCDEF0, idx_rr(2'd2, 2'd1));
        vecs[3] = mkvec(32'hFFFF_FFFF, {32'hFFFFFFFF, 32'h00000000, 32'hA5A5A5A5, 32'h5A5A5A5A}, 0, 1, 1,
                        32'hFFFF_FFF0, 128'hFFFFFFFF_00000000_A5A5A5A5_5A5A5A5A, idx_rr(2'd3, 2'd0));
        vecs[4] = mkvec(32'h0000_0010, {32'h87654321, 32'h0, 32'h0, 32'h00000001}, 1, 0, 0,
                        32'h0000_0010, 128'h87654321_00000000_00000000_00000001, idx_rr(2'd0, 2'd3));

        step(); step();
        rst = 1'b0;
        step();
        chk("reset strobe", 128'(mmu_data_o), 128'd0);
        chk("reset line", mmu_wr_data_o, 128'd0);
        chk("reset index", 128'(mmu_lru_index_o), 128'd0);
        chk("reset req", 128'(mm_rd_req_o), 128'd0);
        chk("reset addr", 128'(mm_addr_o), 128'd0);

        for (int i = 0; i < 5; i++) begin
            run_refill(vecs[i], $sformatf("vec%0d", i));
        end

        // Stray beats while idle must not disturb anything.
        mm_data_valid = 1'b1; mm_data = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("idle stray strobe", 128'(mmu_data_o), 128'd0);
            chk("idle stray req", 128'(mm_rd_req_o), 128'd0);
        end
        mm_data_valid = 1'b0;
        chk("idle stray line hold", mmu_wr_data_o, vecs[4].exp_line);

        // Reset after two beats abandons the refill.
        begin
            int p0;
            p0 = pulses;
            ic_access = 1'b1; ic_miss = 1'b1; ic_addr = 32'h0000_2000;
            step();
            ic_access = 1'b0; ic_miss = 1'b0; mm_req_ready = 1'b1;
            step();
            mm_req_ready = 1'b0;
            for (int b = 0; b < 2; b++) begin
                mm_data_valid = 1'b1; mm_data = 32'h1111_0000 + 32'(b);
                step();
            end
            mm_data_valid = 1'b0;
            rst = 1'b1;
            step();
            rst = 1'b0;
            chk("midreset line", mmu_wr_data_o, 128'd0);
            chk("midreset index", 128'(mmu_lru_index_o), 128'd0);
            chk("midreset addr", 128'(mm_addr_o), 128'd0);
            for (int b = 0; b < 3; b++) begin
                mm_data_valid = 1'b1; mm_data = 32'h2222_0000;
                step();
            end
            mm_data_valid = 1'b0;
            step();
            chk("midreset no pulse", 128'(pulses - p0), 128'd0);
        end

        v = mkvec(32'h0000_0040, {32'h40404043, 32'h40404042, 32'h40404041, 32'h40404040}, 0, 0, 0,
                  32'h0000_0040, 128'h40404043_40404042_40404041_40404040, idx_rr(2'd0, 2'd3));
        run_refill(v, "after reset");

`ifdef SEGRE_ICACHE_LRU_EN
        // Touch lines 0..3 in order, re-touch 0: line 1 becomes oldest.
        for (int i = 0; i < 5; i++) begin
            ic_access = 1'b1; ic_miss = 1'b0; ic_hit_index = (i == 4) ? 2'd0 : 2'(i);
            step();
        end
        ic_access = 1'b0;
        v = mkvec(32'h0000_0500, {32'h4, 32'h3, 32'h2, 32'h1}, 0, 0, 0, 32'h0000_0500,
                  128'h00000004_00000003_00000002_00000001, 2'd1);
        run_refill(v, "lru");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
